// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and state encoding for the UART blocks.
//                Holds the default oversampling ratio, the default frame
//                width, and the 3-bit receiver state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Sample ticks per bit period. Must stay even and at least 4 so that a
    // mid-bit sample point exists.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Data bits per frame (LSB first, no parity, one stop bit).
    localparam int DATA_BITS_DEFAULT  = 8;

    // Receiver states.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
//  Module      : uart_rx_if
//  Description : Bundles the serial-side inputs and byte-side outputs of the
//                UART receiver.
//                  baud_tick   : sample enable at OVERSAMPLE x baud
//                  bit_in      : raw serial line, idle high
//                  data_out    : last correctly framed byte
//                  received    : one-clk strobe, data_out valid same cycle
//                  frame_error : one-clk strobe, stop bit sampled low
//                  busy        : high while a frame is being processed
//                Modport master drives the line, slave is the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 bit_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 received;
    logic                 frame_error;
    logic                 busy;

    modport master (
        output baud_tick,
        output bit_in,
        input  data_out,
        input  received,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  baud_tick,
        input  bit_in,
        output data_out,
        output received,
        output frame_error,
        output busy
    );
endinterface : uart_rx_if

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Runs every clock (no enable). The reset value is a parameter
//                so idle-high lines do not see a false edge after reset.
//                  clk : destination clock
//                  rst : asynchronous, active-high reset
//                  i_d : asynchronous input
//                  o_q : synchronized output, 2 clk latency
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 serial-to-parallel receiver, LSB first, oversampled.
//                The start edge is confirmed at mid start bit; every later
//                sample is taken one full bit period apart, which lands in
//                the middle of each data bit and of the stop bit.
//                  clk    : system clock
//                  reset  : asynchronous, active-high reset
//                  bus    : uart_rx_if.slave (baud_tick, bit_in in;
//                           data_out, received, frame_error, busy out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  wire logic  clk,
    input  wire logic  reset,
    uart_rx_if.slave   bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (bus.bit_in),
        .o_q (w_rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_received;
    logic                 r_frame_error;

    rx_state_t            w_state_nx;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic [IDX_W-1:0]     w_idx_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic [DATA_BITS-1:0] w_data_nx;
    logic                 w_received_nx;
    logic                 w_frame_error_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RX_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_received    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_idx         <= w_idx_nx;
            r_shift       <= w_shift_nx;
            r_data_out    <= w_data_nx;
            // Strobes default low every clock, so they last exactly one
            // cycle whatever baud_tick does next.
            r_received    <= w_received_nx;
            r_frame_error <= w_frame_error_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Everything except the strobes holds while
    // baud_tick is low.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_idx_nx         = r_idx;
        w_shift_nx       = r_shift;
        w_data_nx        = r_data_out;
        w_received_nx    = 1'b0;
        w_frame_error_nx = 1'b0;

        if (bus.baud_tick) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nx = RX_START;
                        w_cnt_nx   = '0;
                    end
                end

                RX_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        w_cnt_nx = '0;
                        if (!w_rx_s) begin
                            w_state_nx = RX_DATA;
                            w_idx_nx   = '0;
                        end else begin
                            // Line went back high before mid start bit:
                            // treat as a glitch, no pulse.
                            w_state_nx = RX_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        // LSB arrives first, so shifting right from the MSB
                        // leaves bit 0 in position 0 after the last sample.
                        w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_cnt_nx   = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nx = RX_STOP;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end

                RX_STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nx = '0;
                        if (w_rx_s) begin
                            // Returning to IDLE mid stop bit lets a start
                            // edge right after the stop bit be caught.
                            w_data_nx     = r_shift;
                            w_received_nx = 1'b1;
                            w_state_nx    = RX_IDLE;
                        end else begin
                            w_frame_error_nx = 1'b1;
                            w_state_nx       = RX_BREAK;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end

                RX_BREAK: begin
                    // A held-low line must go high before a new frame can
                    // start, otherwise a break would retrigger endlessly.
                    if (w_rx_s) begin
                        w_state_nx = RX_IDLE;
                        w_cnt_nx   = '0;
                    end
                end

                default: begin
                    w_state_nx = RX_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.data_out    = r_data_out;
    assign bus.received    = r_received;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = (r_state != RX_IDLE);

endmodule : uart_rx

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel receiver for 8N1 asynchronous frames, LSB first.
- Sits downstream of uart_tx on the opposite end of the serial link, or on the loopback path from the board RX pin.
- Uses the same oversampling clock convention as the transmitter: one sample tick equals one baud/OVERSAMPLE interval.
- Delivers each received byte with a one-cycle strobe to the game/display logic.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit period; must be an even value ≥ 4.
- DATA_BITS, 8, data bits per frame; LSB first, no parity, one stop bit.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values.
- baud_tick  input  1  sample enable at OVERSAMPLE×baud; tie to 1 when clk already runs at 16×baud.
- bit_in  input  1  raw serial line, idle high, asynchronous to clk.
- data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- received  output  1  one-clk pulse; data_out is valid in the same cycle.
- frame_error  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset values:
  - data_out = 0, received = 0, frame_error = 0, busy = 0.
  - State = IDLE; synchronizer flops = 1.
  - Tick counter = 0; bit index = 0; shift register = 0.
- Input conditioning:
  - bit_in passes through a 2-flop synchronizer (rx_s) with no enable.
  - Synchronizer latency is 2 clk cycles.
- Tick counter:
  - Width $clog2(OVERSAMPLE); advances only when baud_tick = 1.
  - Cleared on every state entry.
- Bit index: width $clog2(DATA_BITS+1).
- State machine (all transitions qualified by baud_tick unless noted):
  - IDLE:
    - busy = 0.
    - On a tick with rx_s = 0, go to START with the counter cleared.
  - START:
    - At counter = OVERSAMPLE/2 − 1 (mid start bit), sample rx_s.
    - rx_s = 0: go to DATA, counter = 0, bit index = 0.
    - rx_s = 1: glitch. Return to IDLE with no output pulse.
  - DATA:
    - At counter = OVERSAMPLE − 1, shift rx_s into the MSB of the shift register (right shift), increment the bit index, clear the counter.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP:
    - At counter = OVERSAMPLE − 1, sample rx_s.
    - rx_s = 1: data_out ← shift register; received = 1 for exactly one clk; go to IDLE.
    - rx_s = 0: frame_error = 1 for one clk; data_out unchanged; go to BREAK.
  - BREAK:
    - Wait for a tick with rx_s = 1, then go to IDLE.
    - This prevents a held-low line (break) from retriggering frames.
- Output timing:
  - received and frame_error assert on the clk edge that processes the stop-sample tick.
  - Both deassert on the next edge, regardless of baud_tick.
- End-to-end latency: the falling edge on bit_in reaches received in 2 + (OVERSAMPLE/2) + DATA_BITS·OVERSAMPLE + OVERSAMPLE sample ticks, ±1 tick of edge quantisation.
  - For the defaults this is 2 clk + 152 ticks.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so a start edge arriving immediately after the stop bit is caught.
  - No minimum idle gap is required.
- received and frame_error never assert in the same cycle.
- Reset mid-frame: immediate return to IDLE; the partial byte is discarded; no pulse.
- baud_tick = 0: all counters and state hold; only the synchronizer keeps running.

Decomposition:
- Package uart_pkg holds:
  - Localparams OVERSAMPLE_DEFAULT = 16 and DATA_BITS_DEFAULT = 8.
  - The rx state encoding: IDLE, START, DATA, STOP, BREAK as 3-bit constants.
  - uart_tx later adopts the same package for its constants.
- One sub-module: sync_2ff.
  - Parameterisable reset value; here reset value = 1.
  - Reused for the other asynchronous board inputs.

Test Plan:
All cases use baud_tick tied to 1 and OVERSAMPLE = 16 unless stated.
- Frame 0x55, stop = 1, 16 clk/bit:
  - data_out = 0x55.
  - received pulses exactly once, 1 clk wide.
  - frame_error stays 0; busy drops when the pulse fires.
- Glitch: bit_in low for 4 clk, then high:
  - No received or frame_error pulse.
  - State back in IDLE by the START sample; data_out unchanged.
- Frame 0xA3 with the stop bit forced low, line then held low 64 clk, then frame 0x3C:
  - One frame_error pulse; data_out stays at its previous value.
  - No retrigger during the low hold.
  - 0x3C is then received correctly.
- Back-to-back frames 0x00 then 0xFF with zero idle gap:
  - Two received pulses; data_out = 0x00, then 0xFF.
- Reset asserted during data bit 3 of 0x81, then frame 0x7E:
  - Outputs go to 0 asynchronously.
  - No pulse for 0x81; 0x7E is received correctly.
- Loopback from uart_tx bit_out, with baud_tick pulsing 1 in 4 clk, bytes 0x00..0xFF:
  - All 256 bytes are received in order.
  - frame_error is never asserted.
